// File: rtl/uart_rx_drain_ctrl_if.sv
// FIFO-side and host-side handshake bundle for uart_rx_drain_ctrl.
// master = FIFO/host environment, slave = the drain controller.
interface uart_rx_drain_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  // FIFO side
  logic                  push_hs;
  logic                  fifo_valid;
  logic                  fifo_ready;
  logic [DATA_WIDTH-1:0] fifo_data;
  // host side
  logic                  host_req;
  logic                  host_ack;
  logic [DATA_WIDTH-1:0] host_data;
  logic                  host_underrun;

  modport master (
    output push_hs, fifo_valid, fifo_data, host_req,
    input  fifo_ready, host_ack, host_data, host_underrun
  );

  modport slave (
    input  push_hs, fifo_valid, fifo_data, host_req,
    output fifo_ready, host_ack, host_data, host_underrun
  );
endinterface

// File: rtl/uart_rx_drain_ctrl.sv
// UART RX drain sequencer: host read -> FIFO pop -> captured byte + ack, occupancy tracking, irq.
// Optional character timeout compiled in with `define UART_RX_TIMEOUT_EN.
module uart_rx_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int LVL_WIDTH  = 3,
  parameter int TO_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  uart_rx_drain_ctrl_if.slave  bus,
  input  logic [LVL_WIDTH-1:0] cfg_thresh,
  input  logic [TO_WIDTH-1:0]  cfg_timeout,
  output logic [LVL_WIDTH-1:0] level,
  output logic                 irq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] CAP  = 2'd2;
  localparam logic [1:0] ACK  = 2'd3;

  localparam logic [LVL_WIDTH-1:0] DEPTH_L = LVL_WIDTH'(DEPTH);

  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic                  underrun_reg;
  logic [DATA_WIDTH-1:0] host_data_reg;
  logic [LVL_WIDTH-1:0]  level_reg;
  logic [LVL_WIDTH-1:0]  level_next;
  logic                  irq_reg;
  logic                  to_flag;
  logic                  pop;
  logic                  thresh_hit;

  // ---------------- transaction FSM ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.host_req) begin
          state_next = bus.fifo_valid ? POP : ACK;
        end
      end
      POP:     state_next = CAP;
      CAP:     state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      underrun_reg  <= 1'b0;
      host_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      // The empty/non-empty decision is latched when the request is accepted.
      if (state_reg == IDLE && bus.host_req) begin
        underrun_reg <= ~bus.fifo_valid;
      end
      if (state_reg == CAP) begin
        host_data_reg <= bus.fifo_data;
      end
    end
  end

  assign bus.fifo_ready    = (state_reg == POP);
  assign bus.host_ack      = (state_reg == ACK);
  assign bus.host_underrun = (state_reg == ACK) & underrun_reg;
  assign bus.host_data     = host_data_reg;

  // ---------------- occupancy ----------------
  assign pop = bus.fifo_ready & bus.fifo_valid;

  always_comb begin
    level_next = level_reg;
    if (bus.push_hs && !pop && level_reg != DEPTH_L) begin
      level_next = level_reg + 1'b1;
    end else if (pop && !bus.push_hs && level_reg != '0) begin
      level_next = level_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
    end
  end

  assign level = level_reg;

  // ---------------- character timeout ----------------
`ifdef UART_RX_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt_reg;
  logic [TO_WIDTH-1:0] to_cnt_next;
  logic                to_flag_reg;
  logic                to_flag_next;
  logic                to_clear;

  assign to_clear = bus.push_hs | pop | (level_reg == '0);

  always_comb begin
    to_cnt_next = to_cnt_reg + 1'b1;
    if (to_clear) begin
      to_cnt_next = '0;
    end else if (to_cnt_reg >= cfg_timeout) begin
      // Clamp also covers cfg_timeout being lowered below the running count.
      to_cnt_next = cfg_timeout;
    end
  end

  always_comb begin
    to_flag_next = to_flag_reg;
    if (bus.push_hs || pop) begin
      to_flag_next = 1'b0;
    end else if (cfg_timeout != '0 && level_reg != '0 && to_cnt_next == cfg_timeout) begin
      to_flag_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_reg  <= '0;
      to_flag_reg <= 1'b0;
    end else begin
      to_cnt_reg  <= to_cnt_next;
      to_flag_reg <= to_flag_next;
    end
  end

  assign to_flag = to_flag_reg;
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
  assign to_flag = 1'b0;
`endif

  // ---------------- interrupt ----------------
  assign thresh_hit = (cfg_thresh != '0) && (level_reg >= cfg_thresh);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= thresh_hit | to_flag;
    end
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Bench for uart_rx_drain_ctrl: FIFO stand-in, read scoreboard, threshold vector table, corner sequences.
module tb_uart_rx_drain_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] cfg_thresh;
  logic [7:0] cfg_timeout;
  logic [2:0] level;
  logic       irq;

  uart_rx_drain_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_drain_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .cfg_thresh  (cfg_thresh),
    .cfg_timeout (cfg_timeout),
    .level       (level),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // ---------------- 4-entry FIFO stand-in, registered read data ----------------
  logic [7:0] push_data;
  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  int         m_cnt;
  logic [7:0] m_data;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      m_cnt  <= 0;
      m_data <= 8'h00;
    end else begin
      if (bus.fifo_ready && m_cnt != 0) begin
        m_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (bus.push_hs) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      m_cnt <= m_cnt + (bus.push_hs ? 1 : 0) - ((bus.fifo_ready && m_cnt != 0) ? 1 : 0);
    end
  end

  assign bus.fifo_valid = (m_cnt != 0);
  assign bus.fifo_data  = m_data;

  // ---------------- scoreboard and bookkeeping ----------------
  typedef struct packed {
    logic [7:0] data;
    logic       und;
  } sb_t;

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic [2:0] thresh;
    logic [2:0] exp_level;
    logic       exp_irq;
  } vec_t;

  sb_t        sb [$];
  logic [7:0] exp_bytes [$];
  int         ack_log [$];
  logic [7:0] last_data;
  int         total;
  int         bad;
  int         cycle;
  int         ready_pulses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(negedge clk);
    cycle++;
    if (bus.fifo_ready) ready_pulses++;
    if (rstn) chk("level", 32'(level), 32'(m_cnt));
    if (bus.host_ack) begin
      ack_log.push_back(cycle);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack with data 0x%0h, expected none", bus.host_data);
      end else begin
        e = sb.pop_front();
        chk("host_data", 32'(bus.host_data), 32'(e.data));
        chk("host_underrun", 32'(bus.host_underrun), 32'(e.und));
        $display("ack: data=0x%02h underrun=%0b cycle=%0d", bus.host_data, bus.host_underrun, cycle);
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
    push_data   = b;
    bus.push_hs = 1'b1;
    tick();
    bus.push_hs = 1'b0;
  endtask

  // Queue the expected result for the next request, from what the bench has pushed.
  task automatic expect_read(output int lat, output int pops);
    sb_t e;
    if (exp_bytes.size() != 0) begin
      e.data    = exp_bytes.pop_front();
      e.und     = 1'b0;
      last_data = e.data;
      lat       = 3;
      pops      = 1;
    end else begin
      e.data = last_data;
      e.und  = 1'b1;
      lat    = 1;
      pops   = 0;
    end
    sb.push_back(e);
  endtask

  task automatic do_read();
    int lat;
    int pops;
    int start;
    int got;
    int n0;
    expect_read(lat, pops);
    ready_pulses = 0;
    start        = cycle;
    n0           = ack_log.size();
    got          = -1;
    bus.host_req = 1'b1;
    for (int i = 0; i < 10 && got < 0; i++) begin
      tick();
      bus.host_req = 1'b0;
      if (ack_log.size() != n0) got = cycle - start;
    end
    chk("ack_latency", 32'(got), 32'(lat));
    chk("fifo_ready_pulses", 32'(ready_pulses), 32'(pops));
    tick();
  endtask

  vec_t tbl [9];

  initial begin
    int   lat;
    int   pops;
    int   n;
    int   first;
    int   start;

    total = 0; bad = 0; cycle = 0; ready_pulses = 0; last_data = 8'h00;
    rstn = 1'b0;
    bus.push_hs = 1'b0; bus.host_req = 1'b0; push_data = 8'h00;
    cfg_thresh = 3'd0; cfg_timeout = 8'd0;

    tbl[0] = '{1'b1, 8'h31, 3'd3, 3'd1, 1'b0};
    tbl[1] = '{1'b1, 8'h32, 3'd3, 3'd2, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 3'd3, 3'd3, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 3'd3, 3'd3, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 3'd0, 3'd3, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 3'd0, 3'd3, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 3'd3, 3'd3, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 3'd4, 3'd3, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 3'd3, 3'd3, 1'b1};

    // Reset values
    tick(); tick();
    chk("rst_fifo_ready", 32'(bus.fifo_ready), 32'd0);
    chk("rst_host_ack", 32'(bus.host_ack), 32'd0);
    chk("rst_host_underrun", 32'(bus.host_underrun), 32'd0);
    chk("rst_host_data", 32'(bus.host_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rstn = 1'b1;
    tick();

    // Empty read: underrun, one-cycle latency, no pop
    do_read();

    // Single byte
    push_byte(8'hA5);
    do_read();

    // Four bytes drained by a held request, then an underrun
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    for (int i = 0; i < 5; i++) expect_read(lat, pops);
    ack_log.delete();
    start = cycle;
    bus.host_req = 1'b1;
    for (int i = 0; i < 80 && ack_log.size() < 5; i++) tick();
    bus.host_req = 1'b0;
    chk("held_ack_count", 32'(ack_log.size()), 32'd5);
    if (ack_log.size() == 5) begin
      chk("held_first_latency", 32'(ack_log[0] - start), 32'd3);
      for (int i = 0; i < 3; i++) chk("held_ack_spacing", 32'(ack_log[i+1] - ack_log[i]), 32'd4);
      chk("held_underrun_spacing", 32'(ack_log[4] - ack_log[3]), 32'd2);
    end
    tick();

    // Threshold vector table
    for (int i = 0; i < 9; i++) begin
      cfg_thresh  = tbl[i].thresh;
      push_data   = tbl[i].data;
      bus.push_hs = tbl[i].push;
      if (tbl[i].push) exp_bytes.push_back(tbl[i].data);
      tick();
      bus.push_hs = 1'b0;
      chk("tbl_level", 32'(level), 32'(tbl[i].exp_level));
      chk("tbl_irq", 32'(irq), 32'(tbl[i].exp_irq));
      $display("vec %0d: push=%0b thresh=%0d level=%0d irq=%0b", i, tbl[i].push, tbl[i].thresh, level, irq);
    end

    // One read at level 3: irq falls one cycle after level reaches 2
    expect_read(lat, pops);
    bus.host_req = 1'b1;
    tick();
    bus.host_req = 1'b0;
    chk("rd_pop_cycle_ready", 32'(bus.fifo_ready), 32'd1);
    chk("rd_pop_cycle_irq", 32'(irq), 32'd1);
    tick();
    chk("rd_cap_level", 32'(level), 32'd2);
    chk("rd_cap_irq", 32'(irq), 32'd1);
    tick();
    chk("rd_ack_strobe", 32'(bus.host_ack), 32'd1);
    chk("rd_ack_irq", 32'(irq), 32'd0);
    tick();

    // Push and pop in the same cycle at level 2
    cfg_thresh = 3'd0;
    expect_read(lat, pops);
    bus.host_req = 1'b1;
    tick();
    bus.host_req = 1'b0;
    chk("sim_pop_ready", 32'(bus.fifo_ready), 32'd1);
    exp_bytes.push_back(8'h77);
    push_data   = 8'h77;
    bus.push_hs = 1'b1;
    tick();
    bus.push_hs = 1'b0;
    chk("sim_level", 32'(level), 32'd2);
    tick();
    tick();
    do_read();
    do_read();
    chk("drained_level", 32'(level), 32'd0);

    // Character timeout
    cfg_timeout = 8'd10;
    cfg_thresh  = 3'd0;
    tick();
    push_byte(8'h5A);
    first = -1;
    for (int k = 1; k <= 30 && first < 0; k++) begin
      tick();
      if (irq) first = k;
    end
`ifdef UART_RX_TIMEOUT_EN
    chk("timeout_irq_delay", 32'(first), 32'd11);
    expect_read(lat, pops);
    bus.host_req = 1'b1;
    tick();
    bus.host_req = 1'b0;
    chk("to_pop_irq", 32'(irq), 32'd1);
    tick();
    chk("to_cap_irq", 32'(irq), 32'd1);
    tick();
    chk("to_ack_irq", 32'(irq), 32'd0);
    tick();
`else
    chk("timeout_disabled_irq", 32'(first), 32'hFFFF_FFFF);
    do_read();
`endif
    for (n = 0; n < 3; n++) tick();
    chk("final_irq", 32'(irq), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
